// File: rtl/poly_axis_tx_if.sv
// poly_axis_tx_if: AXI4-Stream bundle carrying polynomial beats.
//   tdata  - beat payload
//   tkeep  - byte enables, all ones on a valid beat
//   tlast  - marks the final beat of a polynomial
//   tvalid - source has a beat
//   tready - sink accepts the beat
interface poly_axis_tx_if #(
   parameter int DWIDTH = 256
);
   logic [DWIDTH-1:0]   tdata;
   logic [DWIDTH/8-1:0] tkeep;
   logic                tlast;
   logic                tvalid;
   logic                tready;

   modport master (output tdata, tkeep, tlast, tvalid, input tready);
   modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/poly_axis_tx.sv
// poly_axis_tx: reads one polynomial from the coefficient RAM, one row per read,
// and streams it out as BEATS_PER_POLY AXI4-Stream beats. Each coefficient is
// zero-extended into a STORE_WIDTH lane, and any coefficient >= Q raises a sticky error.
//   clk, rst_n   - clock and synchronous active-low reset
//   start_i      - request to send one polynomial (ignored while busy_o)
//   busy_o       - transfer in progress, including the done_o cycle
//   done_o       - one-cycle pulse after the last beat handshake
//   coeff_err_o  - sticky out-of-range flag, cleared on an accepted start
//   rd_en_o      - RAM read strobe (data returns exactly one cycle later)
//   rd_addr_o    - RAM row, equal to the beat index
//   rd_data_i    - one row of COEFFS_PER_BEAT coefficients
//   m_axis       - stream output (master side)

// One lane: zero-extend a coefficient and flag it if it is out of range.
module poly_axis_tx_lane #(
   parameter int STORE_WIDTH = 16,
   parameter int COEFF_WIDTH = 12,
   parameter int Q           = 3329
) (
   input  logic [COEFF_WIDTH-1:0] coeff,
   output logic [STORE_WIDTH-1:0] lane,
   output logic                   oor
);
   localparam logic [COEFF_WIDTH:0] QV = (COEFF_WIDTH+1)'(Q);

   assign lane = {{(STORE_WIDTH-COEFF_WIDTH){1'b0}}, coeff};
   assign oor  = ({1'b0, coeff} >= QV);
endmodule

module poly_axis_tx #(
   parameter int DWIDTH          = 256,
   parameter int STORE_WIDTH     = 16,
   parameter int COEFF_WIDTH     = 12,
   parameter int COEFFS_PER_BEAT = 16,
   parameter int BEATS_PER_POLY  = 16,
   parameter int Q               = 3329,
   localparam int BW             = $clog2(BEATS_PER_POLY)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   start_i,
   output logic                                   busy_o,
   output logic                                   done_o,
   output logic                                   coeff_err_o,
   output logic                                   rd_en_o,
   output logic [BW-1:0]                          rd_addr_o,
   input  logic [COEFFS_PER_BEAT*COEFF_WIDTH-1:0] rd_data_i,
   poly_axis_tx_if.master                         m_axis
);
   localparam logic [BW-1:0] LAST_ROW = BW'(BEATS_PER_POLY-1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t state_q, state_d;

   // Two-entry buffer. Each entry holds {tlast, tdata}. The head entry drives the bus.
   logic [DWIDTH:0] head_q, tail_q, wr_beat;
   logic            head_vld_q, tail_vld_q;
   logic            rd_vld_q;          // a read was issued last cycle, so data arrives now
   logic [BW-1:0]   ret_row_q;         // row number of the data arriving now
   logic            pop, credit;
   logic [2:0]      occ;

   logic [COEFFS_PER_BEAT-1:0][STORE_WIDTH-1:0] lanes;
   logic [COEFFS_PER_BEAT-1:0]                  oor;

   for (genvar k = 0; k < COEFFS_PER_BEAT; k++) begin : g_lane
      poly_axis_tx_lane #(
         .STORE_WIDTH(STORE_WIDTH), .COEFF_WIDTH(COEFF_WIDTH), .Q(Q)
      ) u_lane (
         .coeff(rd_data_i[k*COEFF_WIDTH +: COEFF_WIDTH]),
         .lane (lanes[k]),
         .oor  (oor[k])
      );
   end

   assign wr_beat = {(ret_row_q == LAST_ROW), lanes};
   assign pop     = head_vld_q & m_axis.tready;

   // Count entries already buffered plus entries still in flight, then subtract
   // this cycle's pop. A read is allowed only if that total is below two, so
   // returned data always finds a free slot in the cycle it arrives.
   assign occ    = {2'b0, head_vld_q} + {2'b0, tail_vld_q} + {2'b0, rd_vld_q};
   assign credit = (occ < (3'd2 + {2'b0, pop}));

   always_comb begin
      state_d = state_q;
      rd_en_o = 1'b0;
      done_o  = 1'b0;
      busy_o  = (state_q != IDLE);
      case (state_q)
         IDLE:  if (start_i) state_d = RUN;
         RUN: begin
            rd_en_o = credit;
            if (credit && rd_addr_o == LAST_ROW) state_d = DRAIN;
         end
         DRAIN: if (pop && head_q[DWIDTH]) state_d = DONE;
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         head_q      <= '0;
         tail_q      <= '0;
         head_vld_q  <= 1'b0;
         tail_vld_q  <= 1'b0;
         rd_vld_q    <= 1'b0;
         ret_row_q   <= '0;
         rd_addr_o   <= '0;
         coeff_err_o <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_vld_q <= rd_en_o;
         if (state_q == IDLE && start_i) begin
            rd_addr_o   <= '0;
            coeff_err_o <= 1'b0;
         end
         if (rd_en_o) begin
            ret_row_q <= rd_addr_o;
            rd_addr_o <= rd_addr_o + BW'(1);
         end
         if (rd_vld_q && |oor) coeff_err_o <= 1'b1;
         case ({rd_vld_q, pop})
            2'b10: begin
               if (!head_vld_q) begin
                  head_q     <= wr_beat;
                  head_vld_q <= 1'b1;
               end else begin
                  tail_q     <= wr_beat;
                  tail_vld_q <= 1'b1;
               end
            end
            2'b01: begin
               head_q     <= tail_q;
               head_vld_q <= tail_vld_q;
               tail_vld_q <= 1'b0;
            end
            2'b11: begin
               // Write and pop together: the occupancy stays the same and order is kept.
               if (tail_vld_q) begin
                  head_q <= tail_q;
                  tail_q <= wr_beat;
               end else begin
                  head_q <= wr_beat;
               end
            end
            default: ;
         endcase
      end
   end

   assign m_axis.tvalid = head_vld_q;
   assign m_axis.tdata  = head_q[DWIDTH-1:0];
   assign m_axis.tlast  = head_vld_q & head_q[DWIDTH];
   assign m_axis.tkeep  = {(DWIDTH/8){head_vld_q}};
endmodule

// File: tb/tb_poly_axis_tx.sv
// tb_poly_axis_tx: directed bench for poly_axis_tx, with a scoreboard of expected beats.
module tb_poly_axis_tx;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_i = 1'b0;
   logic         busy, done, coeff_err, rd_en;
   logic [3:0]   rd_addr;
   logic [191:0] rd_data = '0;

   poly_axis_tx_if #(.DWIDTH(256)) axis ();

   poly_axis_tx dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy), .done_o(done),
      .coeff_err_o(coeff_err), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
      .rd_data_i(rd_data), .m_axis(axis)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: data is valid one cycle after the read strobe.
   logic [11:0] mem [16][16];
   always @(posedge clk)
      if (rd_en) for (int k = 0; k < 16; k++) rd_data[k*12 +: 12] <= mem[rd_addr][k];

   int tests = 0, fails = 0;
   logic [256:0] sb [$];
   int t0, b0, r0, d0;
   int beat_total = 0, rd_total = 0, done_total = 0, done_cyc = 0, err_rise_cyc = -1000;
   int beat_cyc [0:1023];
   int rd_cyc   [0:1023];
   int outstanding = 0, rd_idx = 0;
   logic prev_stall = 1'b0, prev_err = 1'b0;
   logic [256:0] prev_beat = '0;

   task automatic check(input string tag, input logic [256:0] obs, input logic [256:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sample the DUT once per cycle, away from the active edge.
   task automatic monitor();
      logic pop;
      logic [256:0] e;
      pop = axis.tvalid & axis.tready;
      if (axis.tvalid) check("tkeep", axis.tkeep, {32{1'b1}});
      if (prev_stall) begin
         check("hold_valid", axis.tvalid, 1'b1);
         check("hold_beat", {axis.tlast, axis.tdata}, prev_beat);
      end
      if (rd_en) begin
         check("credit", ((outstanding - int'(pop)) < 2), 1'b1);
         check("rd_addr", rd_addr, rd_idx[3:0]);
         rd_cyc[rd_total] = cyc;
         rd_total++;
         rd_idx++;
      end
      if (pop) begin
         check("sb_nonempty", (sb.size() != 0), 1'b1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("tdata", axis.tdata, e[255:0]);
            check("tlast", axis.tlast, e[256]);
         end
         beat_cyc[beat_total] = cyc;
         beat_total++;
      end
      outstanding = outstanding + int'(rd_en) - int'(pop);
      if (done) begin
         check("busy_at_done", busy, 1'b1);
         done_total++;
         done_cyc = cyc;
      end
      if (coeff_err && !prev_err) err_rise_cyc = cyc;
      prev_err   = coeff_err;
      prev_stall = axis.tvalid & !axis.tready & rst_n;
      prev_beat  = {axis.tlast, axis.tdata};
      if (start_i && !busy) rd_idx = 0;
      if (!rst_n) outstanding = 0;
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_ramp();
      for (int r = 0; r < 16; r++)
         for (int k = 0; k < 16; k++) mem[r][k] = 12'(16*r + k);
   endtask

   task automatic push_poly();
      logic [255:0] d;
      for (int b = 0; b < 16; b++) begin
         for (int k = 0; k < 16; k++) d[16*k +: 16] = {4'b0, mem[b][k]};
         sb.push_back({(b == 15), d});
      end
   endtask

   task automatic do_start();
      push_poly();
      t0 = cyc; b0 = beat_total; r0 = rd_total; d0 = done_total;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("busy_after_start", busy, 1'b1);
      check("err_cleared", coeff_err, 1'b0);
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (done_total == d0 && n < limit) begin tick(); n++; end
      check("done_seen", (done_total != d0), 1'b1);
   endtask

   task automatic wait_beats(input int nb, input int limit);
      int n = 0;
      while ((beat_total - b0) < nb && n < limit) begin tick(); n++; end
      check("beats_reached", ((beat_total - b0) >= nb), 1'b1);
   endtask

   task automatic check_poly_done();
      check("beat_count", beat_total - b0, 16);
      check("rd_count", rd_total - r0, 16);
      check("done_count", done_total - d0, 1);
      check("sb_drained", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int n, rs, resume, dd;
      axis.tready = 1'b1;
      fill_ramp();
      repeat (3) tick();
      rst_n = 1'b1;
      check("rst_tvalid", axis.tvalid, 1'b0);
      check("rst_tkeep", axis.tkeep, 32'h0);
      check("rst_tlast", axis.tlast, 1'b0);
      check("rst_tdata", axis.tdata, 256'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", coeff_err, 1'b0);
      check("rst_rd_en", rd_en, 1'b0);
      check("rst_rd_addr", rd_addr, 4'h0);
      tick();

      // T1: ramp data with a sink that is always ready
      do_start();
      wait_done(60);
      check_poly_done();
      check("t1_first_beat", beat_cyc[b0] - t0, 3);
      check("t1_last_beat", beat_cyc[b0+15] - t0, 18);
      check("t1_done_cyc", done_cyc - t0, 19);
      check("t1_first_rd", rd_cyc[r0] - t0, 1);
      check("t1_last_rd", rd_cyc[r0+15] - t0, 16);
      check("t1_err", coeff_err, 1'b0);
      check("t1_idle", busy, 1'b0);
      tick();

      // T2: tready toggles every cycle
      do_start();
      n = 0;
      while (done_total == d0 && n < 200) begin axis.tready = ~axis.tready; tick(); n++; end
      axis.tready = 1'b1;
      check("t2_done_seen", (done_total != d0), 1'b1);
      check_poly_done();
      tick();

      // T3: a long stall after beat 4
      do_start();
      wait_beats(5, 40);
      axis.tready = 1'b0;
      repeat (2) tick();
      rs = rd_total;
      repeat (8) tick();
      check("t3_reads_stalled", rd_total - rs, 0);
      axis.tready = 1'b1;
      resume = cyc;
      wait_done(60);
      check_poly_done();
      check("t3_no_gap", beat_cyc[b0+15] - resume, 10);
      tick();

      // T4: out-of-range coefficient in row 7, just-in-range value in row 2
      mem[7][3] = 12'd3329;
      mem[2][0] = 12'd3328;
      do_start();
      wait_done(60);
      check_poly_done();
      check("t4_err_rise", err_rise_cyc - t0, 10);
      check("t4_err_sticky", coeff_err, 1'b1);
      tick();

      // T5: start pulses in RUN, DRAIN and DONE are ignored; this start also clears the error
      fill_ramp();
      do_start();
      while (cyc - t0 < 5) tick();
      start_i = 1'b1; tick(); start_i = 1'b0;
      while (cyc - t0 < 17) tick();
      start_i = 1'b1; tick(); start_i = 1'b0;
      while (cyc - t0 < 19) tick();
      start_i = 1'b1; tick(); start_i = 1'b0;
      check("t5_no_restart", busy, 1'b0);
      repeat (5) tick();
      check_poly_done();
      check("t5_done_cyc", done_cyc - t0, 19);

      // T6: reset in the middle of a stream, then a clean resend
      do_start();
      wait_beats(9, 40);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sb.delete();
      check("t6_tvalid", axis.tvalid, 1'b0);
      check("t6_tkeep", axis.tkeep, 32'h0);
      check("t6_busy", busy, 1'b0);
      check("t6_rd_en", rd_en, 1'b0);
      dd = done_total;
      repeat (4) tick();
      check("t6_no_done", done_total - dd, 0);
      do_start();
      wait_done(60);
      check_poly_done();
      check("t6_first_rd", rd_cyc[r0] - t0, 1);
      check("t6_first_beat", beat_cyc[b0] - t0, 3);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
